// File: rtl/serial_frame_rx.sv
// serial_frame_rx: frames a sampled serial bit stream into parallel words.
// Frame format: start(0), WIDTH data bits LSB first, even-parity bit, stop(1).
// Ports:
//   clk, clr        - clock, asynchronous active-high reset
//   bit_en, din     - bit qualifier and serial bit (idle level 1)
//   data            - last good word, held between frames
//   valid           - one-cycle pulse when data is updated with a good frame
//   parity_err      - one-cycle pulse: frame ended with bad parity
//   frame_err       - one-cycle pulse: stop bit sampled as 0
//   busy            - high while a frame is in progress
//   good_cnt        - saturating count of good frames
// Latency: strobes appear WIDTH+3 enabled edges after the start-bit edge (inclusive).
module serial_frame_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             r_pbit;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_busy;
  logic [CNT_W-1:0] r_good_cnt;

  // Even parity: data bits together with the parity bit must XOR to 0.
  logic w_par_ok;
  assign w_par_ok = ~((^r_shift) ^ r_pbit);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_pbit       <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_good_cnt   <= '0;
    end else begin
      // Strobes self-clear every edge, enabled or not.
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!din) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift[r_bit_cnt] <= din;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            r_pbit  <= din;
            r_state <= S_STOP;
          end
          S_STOP: begin
            // A 0 stop bit is never treated as the next start bit.
            if (din && w_par_ok) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              if (r_good_cnt != {CNT_W{1'b1}}) begin
                r_good_cnt <= r_good_cnt + 1'b1;
              end
            end
            r_parity_err <= ~w_par_ok;
            r_frame_err  <= ~din;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign good_cnt   = r_good_cnt;

endmodule
